// File: rtl/divider_pkg.sv
// divider_pkg: shared FSM state type, default widths and two's-complement helper for the iterative divider
package divider_pkg;
  localparam int DIV_WIDTH = 16;
  localparam int CNT_W = $clog2(DIV_WIDTH);
  localparam int MAXW = 64;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
  function automatic logic [MAXW-1:0] twos_neg(input logic [MAXW-1:0] x, input logic neg);
    return neg ? ~x + MAXW'(1) : x;
  endfunction
endpackage

// File: rtl/divider_iterative_signed_if.sv
// divider_iterative_signed_if: val/rdy request (dividend, divisor) and response (quotient, remainder, divzero) bundle with master/slave modports
interface divider_iterative_signed_if #(parameter int WIDTH = 16);
  logic req_val;
  logic req_rdy;
  logic [WIDTH-1:0] req_dividend;
  logic [WIDTH-1:0] req_divisor;
  logic resp_val;
  logic resp_rdy;
  logic [WIDTH-1:0] resp_quotient;
  logic [WIDTH-1:0] resp_remainder;
  logic resp_divzero;
  modport master(output req_val, req_dividend, req_divisor, resp_rdy, input req_rdy, resp_val, resp_quotient, resp_remainder, resp_divzero);
  modport slave(input req_val, req_dividend, req_divisor, resp_rdy, output req_rdy, resp_val, resp_quotient, resp_remainder, resp_divzero);
endinterface

// File: rtl/divider_restoring_step.sv
// divider_restoring_step: one restoring-division step; ports rem/din/divisor in, rem_next/q_bit out (combinational)
module divider_restoring_step #(parameter int WIDTH = 16) (
  input  logic [WIDTH:0]   rem,
  input  logic             din,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic             q_bit
);
  logic [WIDTH+1:0] shifted, diff;
  assign shifted = {rem, din};
  assign diff = shifted - {2'b0, divisor};
  assign q_bit = ~diff[WIDTH+1];
  assign rem_next = (WIDTH+1)'(q_bit ? diff : shifted);
endmodule

// File: rtl/divider_iterative_signed.sv
// divider_iterative_signed: signed truncating divider, one bit per cycle; ports clk, reset (async high), io slave (req/resp val-rdy)
module divider_iterative_signed import divider_pkg::*; #(parameter int WIDTH = DIV_WIDTH) (
  input logic clk,
  input logic reset,
  divider_iterative_signed_if.slave io
);
  localparam int CW = $clog2(WIDTH);
  state_e state, state_nx;
  logic [CW-1:0] count;
  logic [WIDTH-1:0] a, dv, quo, rmd, dd_mag, dv_mag, q_fin;
  logic [WIDTH:0] rem, rem_nx;
  logic q_neg, r_neg, dz, qb, accept;
  divider_restoring_step #(.WIDTH(WIDTH)) u_step (
    .rem(rem), .din(a[WIDTH-1]), .divisor(dv), .rem_next(rem_nx), .q_bit(qb)
  );
  assign accept = io.req_val && io.req_rdy;
  assign dd_mag = WIDTH'(twos_neg(MAXW'(io.req_dividend), io.req_dividend[WIDTH-1]));
  assign dv_mag = WIDTH'(twos_neg(MAXW'(io.req_divisor), io.req_divisor[WIDTH-1]));
  assign q_fin = {a[WIDTH-2:0], qb};
  assign io.resp_quotient = quo;
  assign io.resp_remainder = rmd;
  assign io.resp_divzero = dz;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    io.req_rdy = state == IDLE;
    io.resp_val = state == DONE;
    state_nx = state == IDLE ? (accept ? (io.req_divisor == '0 ? DONE : CALC) : IDLE)
             : state == CALC ? (count == '0 ? DONE : CALC)
             : (io.resp_rdy ? IDLE : DONE);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      a <= '0;
      dv <= '0;
      rem <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      quo <= '0;
      rmd <= '0;
      dz <= 1'b0;
    end else if (accept) begin
      count <= CW'(WIDTH-1);
      a <= dd_mag;
      dv <= dv_mag;
      rem <= '0;
      q_neg <= io.req_dividend[WIDTH-1] ^ io.req_divisor[WIDTH-1];
      r_neg <= io.req_dividend[WIDTH-1];
      quo <= '1;
      rmd <= io.req_dividend;
      dz <= io.req_divisor == '0;
    end else if (state == CALC) begin
      count <= count - CW'(1);
      a <= q_fin;
      rem <= rem_nx;
      if (count == '0) begin
        quo <= WIDTH'(twos_neg(MAXW'(q_fin), q_neg));
        rmd <= WIDTH'(twos_neg(MAXW'(rem_nx), r_neg));
      end
    end
  end
endmodule
